cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Pipelined, parameterised carry-lookahead adder with valid/ready handshakes on input and output.
- Stage A registers the per-bit generate/propagate vectors. Stage B resolves all carries through a radix-2 G/P lookahead tree and registers the sum and group G/P.
- Consumes operands from the datapath register file.
- Its group G/P outputs feed the next-level lookahead when several instances are cascaded.

Parameters:
- WIDTH, 16, operand width. Must be a power of 2 and >= 4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a, b, c_in are valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- out_valid  output  1  sum, c_out, g_out, p_out, ovf are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + c_in, mod 2^WIDTH.
- c_out  output  1  carry out of the MSB.
- g_out  output  1  group generate over all WIDTH bits.
- p_out  output  1  group propagate over all WIDTH bits.
- ovf  output  1  signed overflow = carry into MSB XOR c_out.

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous, active-high, sampled on the rising edge.
- Reset:
  - Clears vld_A and vld_B.
  - All data registers go to 0, so out_valid=0, sum=0, c_out=0, g_out=0, p_out=0, ovf=0 from the first edge with rst=1.
  - in_ready=1 in the cycle after rst deasserts.
  - Reset mid-operation discards both in-flight results; no partial result is ever presented.
- Stage A:
  - Loads on in_valid && in_ready.
  - Stores g_A = a & b, p_A = a ^ b (bitwise), c_A = c_in, and sets vld_A=1.
- Stage B:
  - Loads when vld_A && rdy_B.
  - Combinationally from g_A, p_A, c_A, computes block G/P via a log2(WIDTH)-level tree of 2-input cells: G = G_hi | P_hi & G_lo, P = P_hi & P_lo.
  - Derives every carry c[i] by the downward sweep c_hi = G_lo | P_lo & c_lo, with c[0] = c_A.
  - Registers sum = p_A ^ c[WIDTH-1:0], c_out = c[WIDTH], g_out = root G, p_out = root P, ovf = c[WIDTH-1] ^ c[WIDTH].
  - g_out and p_out are independent of c_in.
- Handshake (stall-per-stage, full throughput):
  - rdy_B = !vld_B || out_ready.
  - rdy_A = !vld_A || rdy_B.
  - in_ready = rdy_A.
  - in_ready is combinational from out_ready.
  - vld_B clears on out_valid && out_ready unless a new load occurs on the same edge.
  - vld_A clears on transfer to B unless a new input loads on the same edge.
  - Simultaneous drain and fill of a stage is legal and keeps 1 result per cycle.
- Latency:
  - Accepted at edge t, the result is on the outputs after edge t+1 (2 register stages) with no backpressure.
  - Sustained throughput is 1 result per clock while out_ready=1.
- Ordering and stability:
  - Results leave in acceptance order; none dropped or duplicated.
  - While out_valid && !out_ready, all outputs hold stable.
- Capacity: at most 2 operand sets in flight. in_ready=0 only when both stages are valid and out_ready=0.
- Widths: every intermediate carry vector is WIDTH+1 bits. No truncation except sum mod 2^WIDTH.

Decomposition:
- Shared package (cla_pkg): default WIDTH constant and a LOG2W helper function for tree depth.
- One natural sub-module: cla_gp_tree.
  - Purely combinational.
  - Inputs: g[WIDTH-1:0], p[WIDTH-1:0], c0.
  - Outputs: carries c[WIDTH:0], G, P.
  - Built recursively/generatively from 2-input G/P cells.
- The top holds both pipeline stages and the handshake logic.

Test Plan:
- a=16'hFFFF, b=16'h0001, c_in=0, out_ready=1 -> two edges later sum=16'h0000, c_out=1, g_out=1, p_out=0, ovf=0.
- a=16'h7FFF, b=16'h0001, c_in=0 -> sum=16'h8000, c_out=0, ovf=1, g_out=0, p_out=0.
- a=16'hAAAA, b=16'h5555, c_in=1 -> sum=16'h0000, c_out=1, p_out=1, g_out=0 (full ripple through propagate chain).
- out_ready=0, offer 3 back-to-back operand sets -> first two accepted, in_ready=0 on the third. Raise out_ready -> three results in order on consecutive cycles, outputs stable while stalled.
- Both stages valid, assert rst for one cycle -> next cycle out_valid=0, all outputs 0, in_ready=1. Pre-reset operands never appear.
- 10k random a, b, c_in with random in_valid/out_ready (WIDTH=16 and WIDTH=32) -> every result equals the scoreboard value a+b+c_in, with correct c_out and ovf, in order with no loss.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a.
package cla_pkg;

  // Default operand width; must be a power of two and at least 4.
  localparam int CLA_WIDTH = 16;

  // Depth of the radix-2 lookahead tree for a w-bit operand.
  function automatic int LOG2W(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface cla_pipe_adder_if
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             g_out;
  logic             p_out;
  logic             ovf;

  // Operand producer / result consumer side.
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, g_out, p_out, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, g_out, p_out, ovf
  );

endinterface

// File: rtl/cla_gp_tree.sv
// Radix-2 generate/propagate lookahead tree: group G/P upward, carries downward.
// Latency: purely combinational.
// Backpressure: none.
module cla_gp_tree
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             c0,
  output logic [WIDTH:0]   c,
  output logic             grp_g,
  output logic             grp_p
);

  localparam int LVLS = LOG2W(WIDTH);

  // Level 0 is the root (one node), level LVLS holds the per-bit leaves.
  // Each level has its own lg/lp/lc vectors so no signal feeds back into itself.
  for (genvar lvl = 0; lvl <= LVLS; lvl++) begin : g_lvl
    localparam int NN = 1 << lvl;
    logic [NN-1:0] lg;
    logic [NN-1:0] lp;
    logic [NN-1:0] lc;  // carry into the lowest bit covered by each node

    if (lvl == LVLS) begin : g_leaf
      assign lg = g;
      assign lp = p;
    end else begin : g_merge
      // Upward pass: combine the lo (even) and hi (odd) child spans.
      for (genvar k = 0; k < NN; k++) begin : g_cell
        assign lg[k] = g_lvl[lvl+1].lg[2*k+1] |
                       (g_lvl[lvl+1].lp[2*k+1] & g_lvl[lvl+1].lg[2*k]);
        assign lp[k] = g_lvl[lvl+1].lp[2*k+1] & g_lvl[lvl+1].lp[2*k];
      end
    end

    if (lvl == 0) begin : g_root
      assign lc[0] = c0;
    end else begin : g_sweep
      // Downward pass: lo child inherits the parent carry, hi child gets
      // the carry out of its lo sibling.
      for (genvar k = 0; k < NN / 2; k++) begin : g_cell
        assign lc[2*k]   = g_lvl[lvl-1].lc[k];
        assign lc[2*k+1] = lg[2*k] | (lp[2*k] & g_lvl[lvl-1].lc[k]);
      end
    end
  end

  assign grp_g = g_lvl[0].lg[0];
  assign grp_p = g_lvl[0].lp[0];
  assign c     = {g_lvl[0].lg[0] | (g_lvl[0].lp[0] & c0), g_lvl[LVLS].lc};

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA adder: stage A registers bitwise G/P, stage B registers sum and group G/P.
// Latency: 2 cycles from acceptance to result, 1 result per clock sustained.
// Backpressure: per-stage stall; in_ready drops only when both stages hold data and out_ready=0.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  cla_pipe_adder_if.slave bus
);

  // Stage A state
  logic             vld_a_q, vld_a_d;
  logic [WIDTH-1:0] g_a_q, g_a_d;
  logic [WIDTH-1:0] p_a_q, p_a_d;
  logic             c_a_q, c_a_d;

  // Stage B state
  logic             vld_b_q, vld_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             g_out_q, g_out_d;
  logic             p_out_q, p_out_d;
  logic             ovf_q, ovf_d;

  logic             rdy_a, rdy_b;
  logic             load_a, load_b;
  logic [WIDTH:0]   carry;
  logic             tree_g, tree_p;

  cla_gp_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .g     (g_a_q),
    .p     (p_a_q),
    .c0    (c_a_q),
    .c     (carry),
    .grp_g (tree_g),
    .grp_p (tree_p)
  );

  // Ready chains backwards from the consumer so a full pipe can drain and fill on one edge.
  always_comb begin
    rdy_b  = !vld_b_q || bus.out_ready;
    rdy_a  = !vld_a_q || rdy_b;
    load_a = bus.in_valid && rdy_a;
    load_b = vld_a_q && rdy_b;
  end

  // Next state for both stages; data registers hold unless their stage loads.
  always_comb begin
    vld_a_d = vld_a_q;
    g_a_d   = g_a_q;
    p_a_d   = p_a_q;
    c_a_d   = c_a_q;
    vld_b_d = vld_b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    g_out_d = g_out_q;
    p_out_d = p_out_q;
    ovf_d   = ovf_q;

    if (load_a) begin
      vld_a_d = 1'b1;
      g_a_d   = bus.a & bus.b;
      p_a_d   = bus.a ^ bus.b;
      c_a_d   = bus.c_in;
    end else if (load_b) begin
      vld_a_d = 1'b0;
    end

    if (load_b) begin
      vld_b_d = 1'b1;
      sum_d   = p_a_q ^ carry[WIDTH-1:0];
      c_out_d = carry[WIDTH];
      g_out_d = tree_g;
      p_out_d = tree_p;
      ovf_d   = carry[WIDTH-1] ^ carry[WIDTH];
    end else if (bus.out_ready) begin
      vld_b_d = 1'b0;
    end
  end

  // Pipeline registers; reset empties both stages and zeroes every data flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_q <= 1'b0;
      g_a_q   <= '0;
      p_a_q   <= '0;
      c_a_q   <= 1'b0;
      vld_b_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      g_out_q <= 1'b0;
      p_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vld_a_q <= vld_a_d;
      g_a_q   <= g_a_d;
      p_a_q   <= p_a_d;
      c_a_q   <= c_a_d;
      vld_b_q <= vld_b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      g_out_q <= g_out_d;
      p_out_q <= p_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = rdy_a;
  assign bus.out_valid = vld_b_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.g_out     = g_out_q;
  assign bus.p_out     = p_out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vectors on a 16-bit instance, random traffic on 16 and 32 bits.
// Latency: checks the 2-edge acceptance-to-result path.
// Backpressure: exercises stalls, full-pipe in_ready=0 and reset with both stages occupied.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();

  cla_pipe_adder #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  cla_pipe_adder #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        g;
    logic        p;
    logic        ov;
  } vec_t;

  vec_t vecs[6];

  logic [63:0] q16[$];
  logic [63:0] q32[$];
  logic        acc16 = 1'b0;
  logic        acc32 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {ovf, p, g, c_out, sum[31:0]} from plain integer arithmetic.
  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    logic [63:0] mask;
    logic [63:0] full;
    logic [63:0] nocin;
    logic [63:0] s;
    logic        cout, gen, prop, ov;
    mask  = (64'd1 << w) - 64'd1;
    full  = {32'd0, a} + {32'd0, b} + {63'd0, ci};
    nocin = {32'd0, a} + {32'd0, b};
    s     = full & mask;
    cout  = full[w];
    gen   = nocin[w];
    prop  = (({32'd0, a ^ b}) & mask) == mask;
    ov    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {28'd0, ov, prop, gen, cout, s[31:0]};
  endfunction

  function automatic logic [63:0] obs16();
    return {28'd0, bus16.ovf, bus16.p_out, bus16.g_out, bus16.c_out, 16'd0, bus16.sum};
  endfunction

  function automatic logic [63:0] obs32();
    return {28'd0, bus32.ovf, bus32.p_out, bus32.g_out, bus32.c_out, bus32.sum};
  endfunction

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ci);
    bus16.in_valid = v;
    bus16.a        = a;
    bus16.b        = b;
    bus16.c_in     = ci;
  endtask

  task automatic check_outs16(input string tag, input logic v, input logic [15:0] s,
                              input logic co, input logic g, input logic p, input logic ov);
    check({tag, "_valid"}, {63'd0, bus16.out_valid}, {63'd0, v});
    check({tag, "_sum"},   {48'd0, bus16.sum},       {48'd0, s});
    check({tag, "_cout"},  {63'd0, bus16.c_out},     {63'd0, co});
    check({tag, "_g"},     {63'd0, bus16.g_out},     {63'd0, g});
    check({tag, "_p"},     {63'd0, bus16.p_out},     {63'd0, p});
    check({tag, "_ovf"},   {63'd0, bus16.ovf},       {63'd0, ov});
  endtask

  // Negedge sampling for random traffic: record acceptances, score deliveries.
  task automatic sample_both();
    @(negedge clk);
    acc16 = bus16.in_valid && bus16.in_ready;
    if (acc16) q16.push_back(model(16, {16'd0, bus16.a}, {16'd0, bus16.b}, bus16.c_in));
    if (bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) check("r16_unexpected", 64'(q16.size()), 64'd1);
      else check("r16_result", obs16(), q16.pop_front());
    end
    acc32 = bus32.in_valid && bus32.in_ready;
    if (acc32) q32.push_back(model(32, bus32.a, bus32.b, bus32.c_in));
    if (bus32.out_valid && bus32.out_ready) begin
      if (q32.size() == 0) check("r32_unexpected", 64'(q32.size()), 64'd1);
      else check("r32_result", obs32(), q32.pop_front());
    end
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0);
    bus16.out_ready = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.c_in      = 1'b0;
    bus32.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check_outs16("rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {63'd0, bus16.in_ready}, 64'd1);

    // Directed vectors, one at a time, no backpressure
    for (int i = 0; i < 6; i++) begin
      drive16(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
      @(posedge clk); #1;
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      @(posedge clk); #1;
      check_outs16($sformatf("vec%0d", i), 1'b1, vecs[i].s, vecs[i].co, vecs[i].g, vecs[i].p,
                   vecs[i].ov);
    end

    // Backpressure: three back-to-back offers with out_ready=0
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    drive16(1'b1, 16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    check("bp_rdy_empty", {63'd0, bus16.in_ready}, 64'd1);
    @(posedge clk); #1;
    drive16(1'b1, 16'h0010, 16'h0020, 1'b1);
    @(negedge clk);
    check("bp_rdy_one", {63'd0, bus16.in_ready}, 64'd1);
    @(posedge clk); #1;
    drive16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    check("bp_rdy_full", {63'd0, bus16.in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_rdy", i), {63'd0, bus16.in_ready}, 64'd0);
      check_outs16($sformatf("bp_hold%0d", i), 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    check("bp_rdy_comb", {63'd0, bus16.in_ready}, 64'd1);
    check_outs16("bp_out0", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    check_outs16("bp_out1", 1'b1, 16'h0031, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs16("bp_out2", 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_empty", {63'd0, bus16.out_valid}, 64'd0);

    // Reset with both stages occupied
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    drive16(1'b1, 16'h1111, 16'h1111, 1'b0);
    @(posedge clk); #1;
    drive16(1'b1, 16'h2222, 16'h2222, 1'b0);
    @(posedge clk); #1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("mr_pre_full", {63'd0, bus16.in_ready}, 64'd0);
    check("mr_pre_valid", {63'd0, bus16.out_valid}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outs16("mr_post", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mr_in_ready", {63'd0, bus16.in_ready}, 64'd1);
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mr_no_ghost%0d", i), {63'd0, bus16.out_valid}, 64'd0);
    end

    // Random traffic on both widths with scoreboards
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      if (!bus16.in_valid || acc16) begin
        bus16.in_valid = ($urandom_range(3) != 0);
        bus16.a        = 16'($urandom);
        bus16.b        = 16'($urandom);
        bus16.c_in     = 1'($urandom);
      end
      bus16.out_ready = ($urandom_range(3) != 0);
      if (!bus32.in_valid || acc32) begin
        bus32.in_valid = ($urandom_range(3) != 0);
        bus32.a        = $urandom;
        bus32.b        = $urandom;
        bus32.c_in     = 1'($urandom);
      end
      bus32.out_ready = ($urandom_range(3) != 0);
      sample_both();
    end

    // Drain and confirm nothing was lost
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      bus32.in_valid  = 1'b0;
      bus32.out_ready = 1'b1;
      sample_both();
    end
    check("r16_drained", 64'(q16.size()), 64'd0);
    check("r32_drained", 64'(q32.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
